// File: rtl/os_cache_pkg.sv
// rtl/os_cache_pkg.sv - opcodes, FSM state encodings and saturating-add width rule for os_burst_cache
// Contents:
//   OP_*         3-bit command opcodes
//   ST_*         FSM state encodings (IDLE, WRITE, READ)
//   sat_sum_bits width of the internal sum used by the saturating adder
//   is_psum_op   opcode addresses the psum array
//   is_write_op  opcode runs a WRITE burst
package os_cache_pkg;

    localparam logic [2:0] OP_WR_W  = 3'b000;
    localparam logic [2:0] OP_WR_A  = 3'b001;
    localparam logic [2:0] OP_RD_W  = 3'b010;
    localparam logic [2:0] OP_RD_A  = 3'b011;
    localparam logic [2:0] OP_RD_WA = 3'b100;
    localparam logic [2:0] OP_WR_P  = 3'b101;
    localparam logic [2:0] OP_ACC_P = 3'b110;
    localparam logic [2:0] OP_RD_P  = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    // One guard bit is enough to detect overflow of a two-operand signed add.
    function automatic int sat_sum_bits(input int p_bits);
        return p_bits + 1;
    endfunction

    function automatic logic is_psum_op(input logic [2:0] op);
        return op[2] & (op[1] | op[0]);
    endfunction

    function automatic logic is_write_op(input logic [2:0] op);
        return (op == OP_WR_W) || (op == OP_WR_A) || (op == OP_WR_P) || (op == OP_ACC_P);
    endfunction

endpackage

// File: rtl/os_cache_sat_add.sv
// rtl/os_cache_sat_add.sv - combinational signed saturating adder for psum accumulate
// Ports:
//   a_i   in  P_BITS  signed addend (current psum)
//   b_i   in  P_BITS  signed addend (incoming beat)
//   sum_o out P_BITS  a_i + b_i clamped to [-2^(P_BITS-1), 2^(P_BITS-1)-1]
module os_cache_sat_add
    import os_cache_pkg::*;
#(
    parameter int P_BITS = 16
) (
    input  logic [P_BITS-1:0] a_i,
    input  logic [P_BITS-1:0] b_i,
    output logic [P_BITS-1:0] sum_o
);

    localparam int SW = sat_sum_bits(P_BITS);

    logic [SW-1:0] sum_ext;

    always_comb begin
        sum_ext = {a_i[P_BITS-1], a_i} + {b_i[P_BITS-1], b_i};
        // Guard bit disagreeing with the result sign bit means overflow;
        // the guard bit carries the true sign of the exact sum.
        if (sum_ext[SW-1] != sum_ext[SW-2]) begin
            sum_o = sum_ext[SW-1] ? {1'b1, {(P_BITS-1){1'b0}}} : {1'b0, {(P_BITS-1){1'b1}}};
        end else begin
            sum_o = sum_ext[P_BITS-1:0];
        end
    end

endmodule

// File: rtl/os_burst_cache.sv
// rtl/os_burst_cache.sv - output-stationary PE cache with burst commands and psum accumulate
// Ports:
//   w_clk, w_rst_n                    clock, asynchronous active-low reset
//   w_cmd_valid / r_cmd_ready         command handshake
//   w_cmd_op, w_cmd_w_addr,
//   w_cmd_a_addr, w_cmd_len           opcode, base addresses (w also psum), beats-1
//   w_in_valid / r_in_ready, w_in_data   write beat handshake and data
//   r_out_valid / w_out_ready         read beat handshake
//   r_wout, r_aout, r_pout            read data (unused lanes are 0)
//   r_busy                            burst in progress
//   r_err                             sticky bad-command flag
module os_burst_cache
    import os_cache_pkg::*;
#(
    parameter  int WA_BITS  = 8,
    parameter  int WA_ROWS  = 256,
    parameter  int P_BITS   = 16,
    parameter  int P_ROWS   = 32,
    parameter  int LEN_BITS = 8,
    localparam int WA_AW    = $clog2(WA_ROWS)
) (
    input  logic                w_clk,
    input  logic                w_rst_n,
    input  logic                w_cmd_valid,
    output logic                r_cmd_ready,
    input  logic [2:0]          w_cmd_op,
    input  logic [WA_AW-1:0]    w_cmd_w_addr,
    input  logic [WA_AW-1:0]    w_cmd_a_addr,
    input  logic [LEN_BITS-1:0] w_cmd_len,
    input  logic                w_in_valid,
    output logic                r_in_ready,
    input  logic [P_BITS-1:0]   w_in_data,
    output logic                r_out_valid,
    input  logic                w_out_ready,
    output logic [WA_BITS-1:0]  r_wout,
    output logic [WA_BITS-1:0]  r_aout,
    output logic [P_BITS-1:0]   r_pout,
    output logic                r_busy,
    output logic                r_err
);

    localparam int P_AW = (P_ROWS > 1) ? $clog2(P_ROWS) : 1;

    logic [1:0]          state_q;
    logic [2:0]          op_q;
    logic [WA_AW-1:0]    w_cnt_q, a_cnt_q;
    logic [LEN_BITS-1:0] beat_q;
    logic                issue_done_q;
    logic                err_q;
    logic                out_valid_q;
    logic [WA_BITS-1:0]  wout_q, aout_q;
    logic [P_BITS-1:0]   pout_q;

    logic [WA_BITS-1:0]  w_mem_q [WA_ROWS];
    logic [WA_BITS-1:0]  a_mem_q [WA_ROWS];
    logic [P_BITS-1:0]   p_mem_q [P_ROWS];

    logic                cmd_bad;
    logic                psum_op;
    logic [WA_AW-1:0]    w_cnt_d, a_cnt_d;
    logic [P_AW-1:0]     p_idx;
    logic [P_BITS-1:0]   acc_sum;
    logic                fetch, consume;

    assign psum_op = is_psum_op(op_q);
    assign p_idx   = w_cnt_q[P_AW-1:0];

    // Address checks are done in int so non-power-of-2 row counts compare correctly.
    assign cmd_bad = (is_psum_op(w_cmd_op) && (int'(w_cmd_w_addr) >= P_ROWS)) ||
                     (int'(w_cmd_w_addr) >= WA_ROWS) || (int'(w_cmd_a_addr) >= WA_ROWS);

    // The weight counter doubles as the psum row pointer and wraps at P_ROWS for psum ops.
    always_comb begin
        w_cnt_d = w_cnt_q + WA_AW'(1);
        if (psum_op ? (int'(w_cnt_q) == P_ROWS - 1) : (int'(w_cnt_q) == WA_ROWS - 1)) begin
            w_cnt_d = '0;
        end
        a_cnt_d = (int'(a_cnt_q) == WA_ROWS - 1) ? '0 : a_cnt_q + WA_AW'(1);
    end

    // A new beat is fetched whenever the output register is empty or being drained.
    assign fetch   = (state_q == ST_READ) && !issue_done_q && (!out_valid_q || w_out_ready);
    assign consume = out_valid_q && w_out_ready;

    os_cache_sat_add #(.P_BITS(P_BITS)) u_sat_add (
        .a_i   (p_mem_q[p_idx]),
        .b_i   (w_in_data),
        .sum_o (acc_sum)
    );

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            w_cnt_q      <= '0;
            a_cnt_q      <= '0;
            beat_q       <= '0;
            issue_done_q <= 1'b0;
            err_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            wout_q       <= '0;
            aout_q       <= '0;
            pout_q       <= '0;
            for (int i = 0; i < WA_ROWS; i++) begin
                w_mem_q[i] <= '0;
                a_mem_q[i] <= '0;
            end
            for (int i = 0; i < P_ROWS; i++) begin
                p_mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_cmd_valid) begin
                        if (cmd_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            op_q         <= w_cmd_op;
                            w_cnt_q      <= w_cmd_w_addr;
                            a_cnt_q      <= w_cmd_a_addr;
                            beat_q       <= w_cmd_len;
                            issue_done_q <= 1'b0;
                            state_q      <= is_write_op(w_cmd_op) ? ST_WRITE : ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    if (w_in_valid) begin
                        case (op_q)
                            OP_WR_W:  w_mem_q[w_cnt_q] <= w_in_data[WA_BITS-1:0];
                            OP_WR_A:  a_mem_q[a_cnt_q] <= w_in_data[WA_BITS-1:0];
                            OP_WR_P:  p_mem_q[p_idx]   <= w_in_data;
                            OP_ACC_P: p_mem_q[p_idx]   <= acc_sum;
                            default:  ;
                        endcase
                        w_cnt_q <= w_cnt_d;
                        a_cnt_q <= a_cnt_d;
                        if (beat_q == '0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            beat_q <= beat_q - LEN_BITS'(1);
                        end
                    end
                end
                ST_READ: begin
                    if (fetch) begin
                        out_valid_q <= 1'b1;
                        wout_q <= ((op_q == OP_RD_W) || (op_q == OP_RD_WA)) ? w_mem_q[w_cnt_q] : '0;
                        aout_q <= ((op_q == OP_RD_A) || (op_q == OP_RD_WA)) ? a_mem_q[a_cnt_q] : '0;
                        pout_q <= (op_q == OP_RD_P) ? p_mem_q[p_idx] : '0;
                        w_cnt_q <= w_cnt_d;
                        a_cnt_q <= a_cnt_d;
                        // Separate done flag lets a LEN_BITS counter cover 2^LEN_BITS beats.
                        if (beat_q == '0) begin
                            issue_done_q <= 1'b1;
                        end else begin
                            beat_q <= beat_q - LEN_BITS'(1);
                        end
                    end else if (consume) begin
                        out_valid_q <= 1'b0;
                    end
                    if (issue_done_q && consume) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign r_cmd_ready = (state_q == ST_IDLE);
    assign r_in_ready  = (state_q == ST_WRITE);
    assign r_busy      = (state_q != ST_IDLE);
    assign r_err       = err_q;
    assign r_out_valid = out_valid_q;
    assign r_wout      = wout_q;
    assign r_aout      = aout_q;
    assign r_pout      = pout_q;

endmodule
